// File: rtl/axil_gpio_sequencer_pkg.sv
// Shared AXI-Lite response codes and the write-sequencer state encoding.
package axil_pkg;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, RESP, GAP, DONE} seq_state_t;
endpackage

// File: rtl/axil_gpio_sequencer_if.sv
// AXI-Lite write channels (AW/W/B) between the sequencer and the GPIO slave.
interface axil_gpio_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axil_pkg::*;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    resp_t               bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_gpio_sequencer_timer.sv
// Loadable down-counter that parks at zero; expired is high while the count is zero.
module axil_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (en && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/axil_gpio_sequencer.sv
// AXI-Lite write-only master issuing num_writes incrementing-data writes to GPIO_ADDR.
// Optional watchdog on stalled AW/W/B channels: define AXIL_SEQ_TIMEOUT_EN.
module axil_gpio_sequencer
    import axil_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] GPIO_ADDR      = '0,
    parameter logic [AXI_DATA_WIDTH-1:0] DATA_SEED      = '0,
    parameter int                        GAP_CYCLES     = 4,
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [15:0]           num_writes,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    axil_gpio_sequencer_if.master m_axil
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axil_gpio_sequencer: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    seq_state_t                state, state_n;
    logic [15:0]               remaining, remaining_n;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic                      awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
    logic                      err_n, aw_hs, w_hs, b_hs, gap_load, gap_expired, timeout;

    assign aw_hs = awvalid_q & m_axil.awready;
    assign w_hs  = wvalid_q & m_axil.wready;
    assign b_hs  = bready_q & m_axil.bvalid;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        wdata_n     = wdata_q;
        // each valid retires independently on its own handshake
        awvalid_n   = awvalid_q & ~aw_hs;
        wvalid_n    = wvalid_q & ~w_hs;
        bready_n    = bready_q;
        err_n       = err | timeout;
        gap_load    = 1'b0;
        case (state)
            IDLE: if (start) begin
                err_n = 1'b0;
                if (num_writes == '0) begin
                    state_n = DONE;
                end else begin
                    state_n     = ADDR;
                    remaining_n = num_writes;
                    wdata_n     = DATA_SEED;
                    awvalid_n   = 1'b1;
                    wvalid_n    = 1'b1;
                end
            end
            ADDR: if (!awvalid_n && !wvalid_n) begin
                state_n  = RESP;
                bready_n = 1'b1;
            end
            RESP: if (b_hs) begin
                bready_n    = 1'b0;
                remaining_n = remaining - 16'd1;
                if (m_axil.bresp != RESP_OKAY) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else if (remaining == 16'd1) begin
                    state_n = DONE;
                end else begin
                    state_n  = GAP;
                    gap_load = 1'b1;
                end
            end
            GAP: if (gap_expired) begin
                state_n   = ADDR;
                wdata_n   = wdata_q + AXI_DATA_WIDTH'(1);
                awvalid_n = 1'b1;
                wvalid_n  = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            remaining <= '0;
            wdata_q   <= DATA_SEED;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            wdata_q   <= wdata_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            busy      <= (state_n == ADDR) || (state_n == RESP) || (state_n == GAP);
            done      <= (state_n == DONE);
            err       <= err_n;
        end
    end

    // loaded with GAP_CYCLES-1 on the B handshake so ADDR follows GAP_CYCLES idle cycles
    axil_seq_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (gap_load),
        .load_val (GAP_W'(GAP_CYCLES - 1)),
        .en       (state == GAP),
        .expired  (gap_expired)
    );

`ifdef AXIL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic wd_active, wd_load, wd_expired;

    // any handshake counts as progress; the FSM itself keeps waiting after a timeout
    assign wd_active = (state == ADDR) || (state == RESP);
    assign wd_load   = !wd_active || aw_hs || w_hs || b_hs;

    axil_seq_timer #(.W(WD_W)) u_watchdog (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (wd_load),
        .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .en       (wd_active),
        .expired  (wd_expired)
    );

    assign timeout = wd_active && wd_expired;
`else
    assign timeout = 1'b0;
`endif

    assign m_axil.awaddr  = GPIO_ADDR;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
endmodule

// File: tb/tb_axil_gpio_sequencer.sv
// Scoreboard bench: reactive AXI-Lite slave plus monitor checking writes, gaps, done and err.
module tb_axil_gpio_sequencer;
    import axil_pkg::*;

    localparam int                 DW       = 32;
    localparam int                 AW       = 32;
    localparam logic [AW-1:0]      GPIO     = 32'h0000_0040;
    localparam logic [DW-1:0]      SEED     = 32'h0000_0010;
    localparam int                 GAP      = 4;
    localparam int                 TO       = 16;
    localparam logic [DW/8-1:0]    STRB_ALL = '1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_writes = '0;
    logic        busy, done, err;

    axil_gpio_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_gpio_sequencer #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .GPIO_ADDR      (GPIO),
        .DATA_SEED      (SEED),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .num_writes (num_writes),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_axil     (bus)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          err;
        int unsigned nw;
        int unsigned start_cyc;
    } done_exp_t;

    logic [DW-1:0] exp_data_q[$];
    done_exp_t     done_q[$];

    // slave / monitor state
    int            mode = 1;      // 0 random, 1 always ready, 2 AW late 3, 3 no B, 4 AW late 20
    int            err_at = 99;
    int            wr_idx = 0;
    int            seq_writes = 0;
    int            done_cnt = 0;
    int            aw_wait = 0;
    bit            aw_got, w_got, b_taken, gap_pending, bready_due, prev_done;
    bit            prev_aw_stall, prev_w_stall, prev_awv;
    bit            aw_hs, w_hs, b_hs;
    logic [AW-1:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    int unsigned   last_b_cyc = 0;
    done_exp_t     de;

    always @(negedge aclk) begin
        if (!aresetn) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = RESP_OKAY;
            aw_got = 0; w_got = 0; b_taken = 0; gap_pending = 0; bready_due = 0; prev_done = 0;
            prev_aw_stall = 0; prev_w_stall = 0; prev_awv = 0; aw_wait = 0;
        end else begin
            case (mode)
                1, 3:    begin bus.awready = 1'b1; bus.wready = 1'b1; end
                2:       begin bus.awready = (aw_wait >= 3);  bus.wready = 1'b1; end
                4:       begin bus.awready = (aw_wait >= 20); bus.wready = 1'b1; end
                default: begin
                    bus.awready = ($urandom_range(0, 3) != 0);
                    bus.wready  = ($urandom_range(0, 3) != 0);
                end
            endcase
            if (b_taken) begin bus.bvalid = 1'b0; b_taken = 0; end
            if (!bus.bvalid && aw_got && w_got && mode != 3 &&
                (mode != 0 || $urandom_range(0, 1) == 1)) begin
                bus.bvalid = 1'b1;
                bus.bresp  = (wr_idx == err_at) ? RESP_SLVERR : RESP_OKAY;
            end

            #1;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;

            if (prev_aw_stall) begin
                chk_eq("awvalid_held", bus.awvalid, 1);
                chk_eq("awaddr_stable", bus.awaddr, prev_awaddr);
            end
            if (prev_w_stall) begin
                chk_eq("wvalid_held", bus.wvalid, 1);
                chk_eq("wdata_stable", bus.wdata, prev_wdata);
            end
            if (bus.awvalid) chk_eq("aw_once_per_write", aw_got, 0);
            if (bus.wvalid)  chk_eq("w_once_per_write", w_got, 0);
            if (bus.bready)  chk_eq("bready_after_aw_w", aw_got && w_got, 1);
            if (bready_due)  chk_eq("bready_rise", bus.bready, 1);
            if (bus.awvalid || bus.wvalid || bus.bready) chk_eq("busy_during_xfer", busy, 1);
            if (bus.awvalid && !prev_awv && gap_pending) begin
                chk_eq("gap_len", cyc - last_b_cyc, GAP + 1);
                gap_pending = 0;
            end
            if (prev_done) chk_eq("done_single_pulse", done, 0);

            if (aw_hs) begin
                chk_eq("awaddr", bus.awaddr, GPIO);
                aw_got = 1;
            end
            if (w_hs) begin
                chk_eq("w_expected", exp_data_q.size() != 0, 1);
                chk_eq("wstrb", bus.wstrb, STRB_ALL);
                if (exp_data_q.size() != 0) chk_eq("wdata", bus.wdata, exp_data_q.pop_front());
                w_got = 1;
            end
            bready_due = (aw_hs || w_hs) && aw_got && w_got;
            if (b_hs) begin
                aw_got = 0; w_got = 0; b_taken = 1;
                wr_idx++; seq_writes++;
                last_b_cyc = cyc; gap_pending = 1;
            end

            if (done) begin
                chk_eq("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    chk_eq("done_err", err, de.err);
                    chk_eq("done_writes", seq_writes, de.nw);
                    chk_eq("done_busy_low", busy, 0);
                    chk_eq("writes_left", exp_data_q.size(), 0);
                    if (de.nw == 0) chk_eq("done_latency_zero", cyc - de.start_cyc, 1);
                    else            chk_eq("done_after_last_b", cyc - last_b_cyc, 1);
                end
                gap_pending = 0;
                done_cnt++;
            end

            if (aw_hs) aw_wait = 0;
            else if (bus.awvalid) aw_wait++;
            prev_aw_stall = bus.awvalid && !aw_hs;
            prev_w_stall  = bus.wvalid && !w_hs;
            prev_awaddr   = bus.awaddr;
            prev_wdata    = bus.wdata;
            prev_awv      = bus.awvalid;
            prev_done     = done;
        end
    end

    // inputs change 3 time units after the falling edge, clear of the monitor
    task automatic step();
        @(negedge aclk);
        #3;
    endtask

    task automatic check_reset(input string tag);
        chk_eq({tag, "_awvalid"}, bus.awvalid, 0);
        chk_eq({tag, "_wvalid"},  bus.wvalid, 0);
        chk_eq({tag, "_bready"},  bus.bready, 0);
        chk_eq({tag, "_busy"},    busy, 0);
        chk_eq({tag, "_done"},    done, 0);
        chk_eq({tag, "_err"},     err, 0);
        chk_eq({tag, "_wdata"},   bus.wdata, SEED);
        chk_eq({tag, "_awaddr"},  bus.awaddr, GPIO);
        chk_eq({tag, "_wstrb"},   bus.wstrb, STRB_ALL);
    endtask

    // Reference: writes stop after the first failing response; err if one failed or timed out.
    task automatic run_seq(input int k, input int e_at, input int m, input bit to_exp);
        int          n;
        int          t0;
        done_exp_t   d;
        mode       = m;
        err_at     = e_at;
        wr_idx     = 0;
        seq_writes = 0;
        n = (e_at < k) ? e_at + 1 : k;
        for (int i = 0; i < n; i++) exp_data_q.push_back(SEED + DW'(i));
        d.err = (e_at < k) || to_exp;
        d.nw  = n;
        d.start_cyc = cyc;
        done_q.push_back(d);
        t0 = done_cnt;
        start = 1'b1;
        num_writes = 16'(k);
        step();
        start = 1'b0;
        num_writes = 16'($urandom);
        chk_eq("busy_rise", busy, k != 0);
        chk_eq("awvalid_rise", bus.awvalid, k != 0);
        chk_eq("wvalid_rise", bus.wvalid, k != 0);
        chk_eq("err_cleared_by_start", err, 0);
        for (int c = 0; c < 5000 && done_cnt == t0; c++) step();
        chk_eq("done_seen", done_cnt != t0, 1);
        step();
    endtask

    initial begin
        repeat (3) step();
        check_reset("por");
        aresetn = 1'b1;
        repeat (2) step();

        run_seq(3, 99, 1, 0);   // 0x10, 0x11, 0x12
        run_seq(2, 99, 2, 0);   // AW accepted late, W first
        run_seq(0, 99, 1, 0);   // empty sequence
        run_seq(3, 1, 1, 0);    // second write fails
        run_seq(1, 99, 1, 0);   // start clears err

        // reset while waiting on B, then a clean sequence
        mode = 3; err_at = 99; wr_idx = 0; seq_writes = 0;
        exp_data_q.push_back(SEED);
        start = 1'b1; num_writes = 16'd2;
        step();
        start = 1'b0;
        for (int c = 0; c < 50 && bus.bready !== 1'b1; c++) step();
        chk_eq("reached_resp", bus.bready, 1);
        aresetn = 1'b0;
        #1;
        check_reset("mid_resp");
        exp_data_q.delete();
        done_q.delete();
        repeat (2) step();
        aresetn = 1'b1;
        step();
        run_seq(3, 99, 1, 0);

        for (int i = 0; i < 12; i++)
            run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 8)), 0, 0);

`ifdef AXIL_SEQ_TIMEOUT_EN
        run_seq(1, 99, 4, 1);   // AW stalled past the watchdog limit
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
